ov9281_i2c_arb: RTL and testbench
=================================

# ov9281_i2c_arb

Round-robin arbiter sharing the single camera-sensor I2C register-access master between several requesters (power-up configuration sequencer, runtime exposure/gain control, host debug port). Each requester posts one register read or write. The block grants one requester at a time, drives the master's command port, waits for completion and routes the result back to the owner. It sits between the requesters and the I2C master in the sensor control path.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- REG_ADDR_WIDTH, 16, sensor register address width
- REG_DATA_WIDTH, 8, sensor register data width
- TIMEOUT_CYCLES, 1000000, watchdog limit in i_clk cycles (used only with I2C_ARB_TIMEOUT_EN)
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_REQ  per-requester request; held until grant
- i_req_rw  in  NUM_REQ  per-requester direction; 1 = read, 0 = write
- i_req_addr  in  NUM_REQ*REG_ADDR_WIDTH  packed addresses; requester k at [k*W +: W]
- i_req_wdata  in  NUM_REQ*REG_DATA_WIDTH  packed write data
- o_req_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- o_rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner
- o_rsp_error  out  1  NACK or timeout; qualified by o_rsp_valid
- o_rsp_rdata  out  REG_DATA_WIDTH  read data; 0 for writes and errors
- o_mst_start  out  1  one-cycle command pulse to the master
- o_mst_rw, o_mst_addr, o_mst_wdata  out  1 / REG_ADDR_WIDTH / REG_DATA_WIDTH  latched command fields
- i_mst_busy  in  1  master busy
- i_mst_done  in  1  one-cycle completion pulse
- i_mst_nack  in  1  NACK status; valid with i_mst_done
- i_mst_rdata  in  REG_DATA_WIDTH  read data; valid with i_mst_done
- o_busy  out  1  high in every state except IDLE
- o_owner  out  max(1,$clog2(NUM_REQ))  index of the current or last owner
- o_timeout  out  1  sticky watchdog flag

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: when any i_req bit is high, select a winner by round-robin.
  - Search starts at last_owner+1 mod NUM_REQ.
  - Latch the winner's rw/addr/wdata into o_mst_*.
  - Set o_owner, pulse o_req_gnt[winner], go to ISSUE.
- ISSUE: wait while i_mst_busy = 1. When i_mst_busy = 0, pulse o_mst_start and go to WAIT.
- WAIT: on i_mst_done, capture the result and go to RESP.
  - o_rsp_error <= i_mst_nack.
  - o_rsp_rdata <= (rw & !nack) ? i_mst_rdata : 0.
  - i_mst_done is sampled only in WAIT, including the first WAIT cycle. It is ignored in every other state.
- RESP: pulse o_rsp_valid[owner], set last_owner <= owner, go to IDLE.
- Requester rule: deassert i_req (or present a new command) in the cycle after the grant pulse. A request still high when the arbiter returns to IDLE is treated as a new request.
- The latched command does not change from grant until RESP, regardless of requester inputs.
- Any i_req change outside IDLE has no effect.
- Only one transaction is outstanding at a time. There is no queueing.

## Timing
- Reset values:
  - state = IDLE.
  - o_req_gnt, o_rsp_valid, o_rsp_error, o_rsp_rdata, o_mst_start, o_mst_rw, o_mst_addr, o_mst_wdata, o_busy, o_owner, o_timeout = 0.
  - last_owner = NUM_REQ-1, so requester 0 has first priority.
- Request sampled at edge N:
  - Grant is high in cycle N+1.
  - o_mst_start is high no earlier than cycle N+2 (exactly N+2 if the master is idle).
- Done sampled at edge D:
  - o_rsp_valid is high in cycle D+1.
  - The earliest next grant is high in cycle D+3.
- Simultaneous requests: exactly one grant. All pending requesters are served within NUM_REQ transactions.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight response is dropped, and no o_rsp_valid is produced.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES with no i_mst_done, go to RESP with o_rsp_error = 1 and o_rsp_rdata = 0, and set o_timeout.
  - o_timeout stays set until reset.
  - A late i_mst_done is ignored.
- I2C_ARB_TIMEOUT_EN undefined: WAIT waits indefinitely, no counter is built, and o_timeout is tied to 0.

## Test plan
- Single write: requester 1 writes 0x0100 = 0x01 with the master idle. Expect:
  - gnt = 3'b010 one cycle after the request.
  - Start one cycle later, with o_mst_addr = 0x0100 and o_mst_wdata = 0x01.
  - Master done with nack = 0, then rsp_valid = 3'b010 with error = 0 and rdata = 0.
- Read: requester 2 reads 0x300A; the master returns 0x92. Expect rsp_valid[2] with rdata = 0x92 and error = 0.
- Contention: all three requesters hold requests from reset. Expect grants in order 0, 1, 2, 0, with exactly one outstanding start per transaction.
- NACK: done with nack = 1 on a read. Expect rsp error = 1, rdata = 0, and the next round-robin owner served afterwards.
- Master busy: hold i_mst_busy = 1 for 10 cycles after a grant. Expect no start during busy, and start exactly one cycle after busy falls.
- Reset and timeout:
  - Assert i_rst_n low during WAIT: all outputs 0, no rsp_valid.
  - With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, never send done: error response 17 cycles after start, o_timeout = 1.

Source files
------------

// File: rtl/ov9281_i2c_arb.sv
// Round-robin arbiter that shares the OV9281 I2C register-access master between NUM_REQ requesters.
// The optional WAIT watchdog is built only when I2C_ARB_TIMEOUT_EN is defined.
module ov9281_i2c_arb #(
    parameter int NUM_REQ        = 3,
    parameter int REG_ADDR_WIDTH = 16,
    parameter int REG_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic [NUM_REQ-1:0]                              i_req,
    input  logic [NUM_REQ-1:0]                              i_req_rw,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]               i_req_addr,
    input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]               i_req_wdata,
    output logic [NUM_REQ-1:0]                              o_req_gnt,
    output logic [NUM_REQ-1:0]                              o_rsp_valid,
    output logic                                            o_rsp_error,
    output logic [REG_DATA_WIDTH-1:0]                       o_rsp_rdata,
    output logic                                            o_mst_start,
    output logic                                            o_mst_rw,
    output logic [REG_ADDR_WIDTH-1:0]                       o_mst_addr,
    output logic [REG_DATA_WIDTH-1:0]                       o_mst_wdata,
    input  logic                                            i_mst_busy,
    input  logic                                            i_mst_done,
    input  logic                                            i_mst_nack,
    input  logic [REG_DATA_WIDTH-1:0]                       i_mst_rdata,
    output logic                                            o_busy,
    output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] o_owner,
    output logic                                            o_timeout
);
    localparam int OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]                state_r;
    logic [1:0]                state_next_s;
    logic [OW-1:0]             last_owner_r;
    logic [OW-1:0]             win_idx_s;
    logic                      to_hit_s;
    logic [REG_ADDR_WIDTH-1:0] addr_arr_s  [NUM_REQ];
    logic [REG_DATA_WIDTH-1:0] wdata_arr_s [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr_s[k]  = i_req_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign wdata_arr_s[k] = i_req_wdata[k*REG_DATA_WIDTH +: REG_DATA_WIDTH];
    end

    // Round-robin pick: scanning from the farthest candidate back lets the first one after last_owner win.
    always_comb begin
        logic [OW-1:0] cand;
        cand      = '0;
        win_idx_s = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand      = OW'((int'(last_owner_r) + i) % NUM_REQ);
            win_idx_s = i_req[cand] ? cand : win_idx_s;
        end
    end

    // Next-state logic of the grant / issue / wait / respond sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|i_req) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!i_mst_busy) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (i_mst_done || to_hit_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus all registered outputs; pulses default low every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            last_owner_r <= OW'(NUM_REQ - 1);
            o_req_gnt    <= '0;
            o_rsp_valid  <= '0;
            o_rsp_error  <= 1'b0;
            o_rsp_rdata  <= '0;
            o_mst_start  <= 1'b0;
            o_mst_rw     <= 1'b0;
            o_mst_addr   <= '0;
            o_mst_wdata  <= '0;
            o_busy       <= 1'b0;
            o_owner      <= '0;
        end else begin
            state_r     <= state_next_s;
            o_busy      <= (state_next_s != ST_IDLE);
            o_req_gnt   <= '0;
            o_rsp_valid <= '0;
            o_mst_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|i_req) begin
                        o_owner     <= win_idx_s;
                        o_req_gnt   <= REQ_ONE << win_idx_s;
                        o_mst_rw    <= i_req_rw[win_idx_s];
                        o_mst_addr  <= addr_arr_s[win_idx_s];
                        o_mst_wdata <= wdata_arr_s[win_idx_s];
                    end
                end
                ST_ISSUE: begin
                    if (!i_mst_busy) begin
                        o_mst_start <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_mst_done) begin
                        o_rsp_valid <= REQ_ONE << o_owner;
                        o_rsp_error <= i_mst_nack;
                        o_rsp_rdata <= (o_mst_rw && !i_mst_nack) ? i_mst_rdata : '0;
                    end else if (to_hit_s) begin
                        o_rsp_valid <= REQ_ONE << o_owner;
                        o_rsp_error <= 1'b1;
                        o_rsp_rdata <= '0;
                    end
                end
                ST_RESP: last_owner_r <= o_owner;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] wd_cnt_r;

    assign to_hit_s = (state_r == ST_WAIT) && !i_mst_done && (wd_cnt_r == TO_LIMIT);

    // Watchdog counts WAIT cycles from zero on every entry; the timeout flag is sticky until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt_r  <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (state_r == ST_WAIT) begin
                wd_cnt_r <= wd_cnt_r + CW'(1);
            end else begin
                wd_cnt_r <= '0;
            end
            if (to_hit_s) begin
                o_timeout <= 1'b1;
            end
        end
    end
`else
    assign to_hit_s  = 1'b0;
    assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ov9281_i2c_arb.sv
// Self-checking bench for ov9281_i2c_arb: directed vector table, contention/reset/timeout sequences,
// and randomized rounds against a round-robin reference model.
module tb_ov9281_i2c_arb;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1000000;
`endif

    logic            clk;
    logic            i_rst_n;
    logic [N-1:0]    i_req;
    logic [N-1:0]    i_req_rw;
    logic [N*AW-1:0] i_req_addr;
    logic [N*DW-1:0] i_req_wdata;
    logic [N-1:0]    o_req_gnt;
    logic [N-1:0]    o_rsp_valid;
    logic            o_rsp_error;
    logic [DW-1:0]   o_rsp_rdata;
    logic            o_mst_start;
    logic            o_mst_rw;
    logic [AW-1:0]   o_mst_addr;
    logic [DW-1:0]   o_mst_wdata;
    logic            i_mst_busy;
    logic            i_mst_done;
    logic            i_mst_nack;
    logic [DW-1:0]   i_mst_rdata;
    logic            o_busy;
    logic [1:0]      o_owner;
    logic            o_timeout;

    ov9281_i2c_arb #(
        .NUM_REQ(N), .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_req(i_req), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_req_gnt(o_req_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_error(o_rsp_error),
        .o_rsp_rdata(o_rsp_rdata), .o_mst_start(o_mst_start), .o_mst_rw(o_mst_rw),
        .o_mst_addr(o_mst_addr), .o_mst_wdata(o_mst_wdata), .i_mst_busy(i_mst_busy),
        .i_mst_done(i_mst_done), .i_mst_nack(i_mst_nack), .i_mst_rdata(i_mst_rdata),
        .o_busy(o_busy), .o_owner(o_owner), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int          k;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  mdata;
        logic        nack;
        int          busy;
        logic        spur;
        int          dly;
        logic        exp_err;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic set_cmd(input int k, input logic rw, input logic [15:0] addr, input logic [7:0] wd);
        i_req_rw[k]              = rw;
        i_req_addr[k*AW +: AW]   = addr;
        i_req_wdata[k*DW +: DW]  = wd;
    endtask

    task automatic scramble(input int k);
        set_cmd(k, 1'($urandom_range(0, 1)), 16'($urandom()), 8'($urandom()));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},   o_req_gnt,   0);
        chk({tag, "_valid"}, o_rsp_valid, 0);
        chk({tag, "_err"},   o_rsp_error, 0);
        chk({tag, "_rdata"}, o_rsp_rdata, 0);
        chk({tag, "_start"}, o_mst_start, 0);
        chk({tag, "_rw"},    o_mst_rw,    0);
        chk({tag, "_addr"},  o_mst_addr,  0);
        chk({tag, "_wdata"}, o_mst_wdata, 0);
        chk({tag, "_busy"},  o_busy,      0);
        chk({tag, "_owner"}, o_owner,     0);
        chk({tag, "_tmo"},   o_timeout,   0);
    endtask

    // Entered right after the grant edge; ends one cycle after the response pulse (arbiter back in IDLE).
    task automatic run_after_grant(input int k, input logic rw, input logic [15:0] addr,
                                   input logic [7:0] wd, input int busy, input logic spur,
                                   input int dly, input logic nack, input logic [7:0] mdata,
                                   input logic exp_err, input logic [7:0] exp_rd);
        logic [N-1:0] own;
        own    = '0;
        own[k] = 1'b1;
        i_mst_busy = (busy > 0);
        for (int i = 0; i < busy; i++) begin
            i_mst_done  = spur;
            i_mst_nack  = 1'b1;
            i_mst_rdata = 8'hFF;
            step();
            chk("no_start_while_busy", o_mst_start, 0);
            chk("no_rsp_in_issue", o_rsp_valid, 0);
        end
        i_mst_done = 1'b0;
        i_mst_nack = 1'b0;
        i_mst_busy = 1'b0;
        step();
        chk("start", o_mst_start, 1);
        chk("mst_rw", o_mst_rw, rw);
        chk("mst_addr", o_mst_addr, addr);
        chk("mst_wdata", o_mst_wdata, wd);
        chk("busy_flag", o_busy, 1);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("single_start", o_mst_start, 0);
            chk("early_rsp", o_rsp_valid, 0);
        end
        i_mst_done  = 1'b1;
        i_mst_nack  = nack;
        i_mst_rdata = mdata;
        step();
        i_mst_done  = 1'b0;
        i_mst_nack  = 1'b0;
        i_mst_rdata = 8'h3C;
        chk("rsp_valid", o_rsp_valid, own);
        chk("rsp_error", o_rsp_error, exp_err);
        chk("rsp_rdata", o_rsp_rdata, exp_rd);
        step();
        chk("rsp_pulse_end", o_rsp_valid, 0);
        chk("idle_busy", o_busy, 0);
        chk("no_gnt_in_resp", o_req_gnt, 0);
    endtask

    logic        c_rw   [N];
    logic [15:0] c_addr [N];
    logic [7:0]  c_wd   [N];
    bit          pend   [N];
    int          age    [N];

    initial begin
        int          ord [4];
        int          last;
        int          w;
        logic        nk;
        logic [7:0]  md;
        logic [N-1:0] own;

        tbl[0] = '{1, 1'b0, 16'h0100, 8'h01, 8'h5A, 1'b0, 0,  1'b0, 0, 1'b0, 8'h00};
        tbl[1] = '{2, 1'b1, 16'h300A, 8'h00, 8'h92, 1'b0, 0,  1'b0, 2, 1'b0, 8'h92};
        tbl[2] = '{0, 1'b1, 16'h1234, 8'h00, 8'h55, 1'b1, 0,  1'b0, 1, 1'b1, 8'h00};
        tbl[3] = '{1, 1'b0, 16'h3500, 8'h7F, 8'h00, 1'b0, 10, 1'b1, 3, 1'b0, 8'h00};
        tbl[4] = '{2, 1'b0, 16'h0202, 8'hAA, 8'hEE, 1'b1, 2,  1'b0, 0, 1'b1, 8'h00};
        tbl[5] = '{0, 1'b1, 16'h4F00, 8'h00, 8'hC3, 1'b0, 1,  1'b1, 5, 1'b0, 8'hC3};

        i_rst_n = 1'b0; i_req = '0; i_req_rw = '0; i_req_addr = '0; i_req_wdata = '0;
        i_mst_busy = 1'b0; i_mst_done = 1'b0; i_mst_nack = 1'b0; i_mst_rdata = '0;
        step();
        step();
        check_zero("reset");
        i_rst_n = 1'b1;
        step();
        check_zero("idle_no_req");

        // Directed vectors: single requester each, grant one cycle after the request.
        for (int t = 0; t < 6; t++) begin
            own = '0;
            own[tbl[t].k] = 1'b1;
            set_cmd(tbl[t].k, tbl[t].rw, tbl[t].addr, tbl[t].wd);
            i_req[tbl[t].k] = 1'b1;
            step();
            chk("tbl_gnt", o_req_gnt, own);
            chk("tbl_owner", o_owner, tbl[t].k);
            i_req[tbl[t].k] = 1'b0;
            scramble(tbl[t].k);
            run_after_grant(tbl[t].k, tbl[t].rw, tbl[t].addr, tbl[t].wd, tbl[t].busy, tbl[t].spur,
                            tbl[t].dly, tbl[t].nack, tbl[t].mdata, tbl[t].exp_err, tbl[t].exp_rd);
        end

        // Contention from reset: grants 0,1,2,0 with the next grant exactly two cycles after the response.
        set_cmd(0, 1'b1, 16'h0010, 8'h00);
        set_cmd(1, 1'b0, 16'h0011, 8'h22);
        set_cmd(2, 1'b1, 16'h0012, 8'h00);
        i_req = 3'b111;
        do_reset();
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0;
        for (int t = 0; t < 4; t++) begin
            step();
            own = '0;
            own[ord[t]] = 1'b1;
            chk("rr_gnt", o_req_gnt, own);
            if (t == 3) i_req = '0;
            case (t)
                0: run_after_grant(0, 1'b1, 16'h0010, 8'h00, 0, 1'b0, 0, 1'b0, 8'h40, 1'b0, 8'h40);
                1: run_after_grant(1, 1'b0, 16'h0011, 8'h22, 0, 1'b0, 1, 1'b1, 8'h41, 1'b1, 8'h00);
                2: run_after_grant(2, 1'b1, 16'h0012, 8'h00, 0, 1'b0, 2, 1'b0, 8'h42, 1'b0, 8'h42);
                default: run_after_grant(0, 1'b1, 16'h0010, 8'h00, 0, 1'b0, 3, 1'b0, 8'h43, 1'b0, 8'h43);
            endcase
        end

        // Randomized rounds against the round-robin model.
        i_req = '0;
        do_reset();
        last = N - 1;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            age[k]  = 0;
        end
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
                    pend[k] = 1'b1; age[k] = 0;
                    c_rw[k] = 1'($urandom_range(0, 1));
                    c_addr[k] = 16'($urandom());
                    c_wd[k] = 8'($urandom());
                    set_cmd(k, c_rw[k], c_addr[k], c_wd[k]);
                end
            end
            if (!pend[0] && !pend[1] && !pend[2]) begin
                w = $urandom_range(0, N - 1);
                pend[w] = 1'b1; age[w] = 0;
                c_rw[w] = 1'b1; c_addr[w] = 16'($urandom()); c_wd[w] = 8'($urandom());
                set_cmd(w, c_rw[w], c_addr[w], c_wd[w]);
            end
            for (int k = 0; k < N; k++) i_req[k] = pend[k];
            w = -1;
            for (int i = 1; i <= N; i++) begin
                if (w < 0 && pend[(last + i) % N]) w = (last + i) % N;
            end
            step();
            own = '0;
            own[w] = 1'b1;
            chk("rnd_gnt", o_req_gnt, own);
            chk("rnd_owner", o_owner, w);
            chk("rnd_age", (age[w] < N), 1);
            pend[w] = 1'b0;
            i_req[w] = 1'b0;
            last = w;
            for (int k = 0; k < N; k++) if (pend[k]) age[k]++;
            scramble(w);
            nk = ($urandom_range(0, 3) == 0);
            md = 8'($urandom());
            run_after_grant(w, c_rw[w], c_addr[w], c_wd[w], $urandom_range(0, 3),
                            1'($urandom_range(0, 1)), $urandom_range(0, 4), nk, md,
                            nk, (c_rw[w] && !nk) ? md : 8'h00);
        end
        i_req = '0;
        step();

        // Reset in WAIT drops the response.
        set_cmd(0, 1'b1, 16'hBEEF, 8'h11);
        i_req[0] = 1'b1;
        step();
        chk("rstw_gnt", o_req_gnt, 3'b001);
        i_req[0] = 1'b0;
        step();
        chk("rstw_start", o_mst_start, 1);
        step();
        step();
        i_rst_n = 1'b0;
        #2;
        check_zero("rst_in_wait");
        i_mst_done = 1'b1; i_mst_rdata = 8'h77;
        step();
        i_rst_n = 1'b1;
        step();
        chk("rstw_no_rsp", o_rsp_valid, 0);
        chk("rstw_idle", o_busy, 0);
        i_mst_done = 1'b0;
        step();
        chk("rstw_no_rsp2", o_rsp_valid, 0);

`ifdef I2C_ARB_TIMEOUT_EN
        set_cmd(1, 1'b1, 16'h0A0A, 8'h00);
        i_req[1] = 1'b1;
        step();
        chk("tmo_gnt", o_req_gnt, 3'b010);
        i_req[1] = 1'b0;
        step();
        chk("tmo_start", o_mst_start, 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("tmo_no_early_rsp", o_rsp_valid, 0);
        end
        step();
        chk("tmo_rsp", o_rsp_valid, 3'b010);
        chk("tmo_err", o_rsp_error, 1);
        chk("tmo_rdata", o_rsp_rdata, 0);
        chk("tmo_flag", o_timeout, 1);
        i_mst_done = 1'b1; i_mst_rdata = 8'h99;
        step();
        i_mst_done = 1'b0;
        chk("tmo_late_done", o_rsp_valid, 0);
        step();
        chk("tmo_sticky", o_timeout, 1);
        do_reset();
        #1;
        chk("tmo_cleared", o_timeout, 0);
`else
        chk("tmo_tied", o_timeout, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
